// File: rtl/result_drain.sv
// Result-row drain: frames controller rows, buffers them in a FWFT FIFO and
// streams them over valid/ready. Optional RESULT_DRAIN_ERR_CNT_EN adds err_cnt.
module result_drain #(
  parameter int DATAWIDTH  = 16,
  parameter int N_SIZE     = 5,
  parameter int ACC_WIDTH  = 2*DATAWIDTH,
  parameter int FIFO_DEPTH = 8,
  localparam int SEL_W     = (N_SIZE > 1) ? $clog2(N_SIZE) : 1,
  localparam int ROW_W     = N_SIZE*ACC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             row_valid_in,
  input  logic [SEL_W-1:0] row_sel_in,
  input  logic [ROW_W-1:0] row_data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ROW_W-1:0] m_data,
  output logic [SEL_W-1:0] m_row,
  output logic             m_last,
  output logic             mat_done,
  output logic             busy,
  output logic             seq_err,
  output logic             ovf_err,
  input  logic             clear_err
`ifdef RESULT_DRAIN_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  // Handshake: a row leaves on every rising edge where m_valid && m_ready;
  // m_valid never depends on m_ready and the head is stable while stalled.

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SIZE - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] exp_row_q, exp_row_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             seq_err_q, ovf_err_q, mat_done_q;
  logic [ROW_W-1:0] hold_data_q;
  logic [SEL_W-1:0] hold_row_q;
  logic             hold_last_q;

  logic [ROW_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [SEL_W-1:0] mem_row_q  [FIFO_DEPTH];
  logic             mem_last_q [FIFO_DEPTH];

  logic empty, full, pop, in_seq, seq_ev, push_req, ovf_ev, push, err_ev;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = !empty && m_ready;
  assign in_seq   = (state_q == IDLE) ? (row_sel_in == '0) : (row_sel_in == exp_row_q);
  assign seq_ev   = row_valid_in && !in_seq;
  // Out-of-order rows are still kept inside a frame; only IDLE drops them.
  assign push_req = row_valid_in && ((state_q == COLLECT) || (row_sel_in == '0));
  assign ovf_ev   = push_req && full && !pop;
  assign push     = push_req && !ovf_ev;
  assign err_ev   = seq_ev || ovf_ev;

  // Framing advances on every framed row, even one lost to overflow.
  always_comb begin
    state_d   = state_q;
    exp_row_d = exp_row_q;
    if (push_req) begin
      if (row_sel_in == LAST_SEL) begin
        state_d   = IDLE;
        exp_row_d = '0;
      end else begin
        state_d   = COLLECT;
        exp_row_d = row_sel_in + 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_row_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      seq_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      mat_done_q  <= 1'b0;
      hold_data_q <= '0;
      hold_row_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_row_q  <= exp_row_d;
      count_q    <= count_d;
      seq_err_q  <= seq_ev || (seq_err_q && !clear_err);
      ovf_err_q  <= ovf_ev || (ovf_err_q && !clear_err);
      mat_done_q <= pop && mem_last_q[rd_ptr_q];
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q    <= ptr_inc(rd_ptr_q);
        hold_data_q <= mem_data_q[rd_ptr_q];
        hold_row_q  <= mem_row_q[rd_ptr_q];
        hold_last_q <= mem_last_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= row_data_in;
      mem_row_q[wr_ptr_q]  <= row_sel_in;
      mem_last_q[wr_ptr_q] <= (row_sel_in == LAST_SEL);
    end
  end

  // When empty the last popped row stays visible (all zero after reset).
  assign m_valid  = !empty;
  assign m_data   = empty ? hold_data_q : mem_data_q[rd_ptr_q];
  assign m_row    = empty ? hold_row_q  : mem_row_q[rd_ptr_q];
  assign m_last   = empty ? hold_last_q : mem_last_q[rd_ptr_q];
  assign mat_done = mat_done_q;
  assign busy     = !empty || (state_q == COLLECT);
  assign seq_err  = seq_err_q;
  assign ovf_err  = ovf_err_q;

`ifdef RESULT_DRAIN_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_cnt_q <= '0;
    else if (clear_err)                     err_cnt_q <= err_ev ? 8'd1 : 8'd0;
    else if (err_ev && err_cnt_q != 8'hFF)  err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: directed scenarios plus random traffic
// compared every cycle against a queue-based frame model.
module tb_result_drain;

  localparam int DATAWIDTH  = 16;
  localparam int N_SIZE     = 5;
  localparam int ACC_WIDTH  = 2*DATAWIDTH;
  localparam int FIFO_DEPTH = 8;
  localparam int SEL_W      = $clog2(N_SIZE);
  localparam int ROW_W      = N_SIZE*ACC_WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             row_valid_in;
  logic [SEL_W-1:0] row_sel_in;
  logic [ROW_W-1:0] row_data_in;
  logic             m_valid;
  logic             m_ready;
  logic [ROW_W-1:0] m_data;
  logic [SEL_W-1:0] m_row;
  logic             m_last;
  logic             mat_done;
  logic             busy;
  logic             seq_err;
  logic             ovf_err;
  logic             clear_err;
`ifdef RESULT_DRAIN_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  result_drain #(
    .DATAWIDTH(DATAWIDTH), .N_SIZE(N_SIZE), .ACC_WIDTH(ACC_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_valid_in(row_valid_in), .row_sel_in(row_sel_in),
    .row_data_in(row_data_in), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_last(m_last), .mat_done(mat_done), .busy(busy),
    .seq_err(seq_err), .ovf_err(ovf_err), .clear_err(clear_err)
`ifdef RESULT_DRAIN_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [ROW_W-1:0] data;
    int               row;
    bit               last;
  } ent_t;

  ent_t             exp_q[$];
  int               md_next;     // next row index expected inside a frame
  bit               md_inframe;
  bit               md_seq, md_ovf, md_done;
  int               md_cnt;
  logic [ROW_W-1:0] hold_data;
  int               hold_row;
  bit               hold_last;

  task automatic model_reset();
    exp_q.delete();
    md_next = 0; md_inframe = 0;
    md_seq = 0; md_ovf = 0; md_done = 0; md_cnt = 0;
    hold_data = '0; hold_row = 0; hold_last = 0;
  endtask

  task automatic model_update(input bit v, input int sel, input logic [ROW_W-1:0] data,
                              input bit rdy, input bit clr);
    bit   was_full = (exp_q.size() == FIFO_DEPTH);
    bit   pop      = (exp_q.size() != 0) && rdy;
    bit   framed   = 0;
    bit   seq_ev   = 0;
    bit   ovf_ev   = 0;
    ent_t e;
    md_done = 0;
    if (pop) begin
      e = exp_q.pop_front();
      md_done = e.last;
      hold_data = e.data; hold_row = e.row; hold_last = e.last;
    end
    if (v) begin
      if (!md_inframe) begin
        framed = (sel == 0);
        seq_ev = (sel != 0);
      end else begin
        framed = 1;
        seq_ev = (sel != md_next);
      end
    end
    if (framed) begin
      if (was_full && !pop) ovf_ev = 1;
      else begin
        e.data = data; e.row = sel; e.last = (sel == N_SIZE-1);
        exp_q.push_back(e);
      end
      md_inframe = (sel != N_SIZE-1);
      md_next    = (sel == N_SIZE-1) ? 0 : sel + 1;
    end
    md_seq = seq_ev || (md_seq && !clr);
    md_ovf = ovf_ev || (md_ovf && !clr);
    if (clr)                                md_cnt = (seq_ev || ovf_ev) ? 1 : 0;
    else if ((seq_ev || ovf_ev) && md_cnt < 255) md_cnt++;
  endtask

  task automatic check_outputs();
    check("m_valid", ROW_W'(m_valid), ROW_W'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("m_data", m_data, exp_q[0].data);
      check("m_row",  ROW_W'(m_row), ROW_W'(exp_q[0].row));
      check("m_last", ROW_W'(m_last), ROW_W'(exp_q[0].last));
    end else begin
      check("m_data_hold", m_data, hold_data);
      check("m_row_hold",  ROW_W'(m_row), ROW_W'(hold_row));
      check("m_last_hold", ROW_W'(m_last), ROW_W'(hold_last));
    end
    check("busy",     ROW_W'(busy),     ROW_W'((exp_q.size() != 0) || md_inframe));
    check("mat_done", ROW_W'(mat_done), ROW_W'(md_done));
    check("seq_err",  ROW_W'(seq_err),  ROW_W'(md_seq));
    check("ovf_err",  ROW_W'(ovf_err),  ROW_W'(md_ovf));
`ifdef RESULT_DRAIN_ERR_CNT_EN
    check("err_cnt",  ROW_W'(err_cnt),  ROW_W'(md_cnt));
`endif
  endtask

  // ---------------- drivers ----------------
  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < N_SIZE; k++) r[k*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($urandom);
    return r;
  endfunction

  task automatic run_cycle(input bit v, input int sel, input bit rdy, input bit clr);
    logic [ROW_W-1:0] d;
    @(negedge clk);
    check_outputs();
    d = rand_row();
    row_valid_in = v;
    row_sel_in   = SEL_W'(sel);
    row_data_in  = d;
    m_ready      = rdy;
    clear_err    = clr;
    model_update(v, sel, d, rdy, clr);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) run_cycle(0, 0, rdy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    row_valid_in = 0; m_ready = 0; clear_err = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    model_update(0, 0, '0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; row_valid_in = 0; row_sel_in = '0; row_data_in = '0;
    m_ready = 0; clear_err = 0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_update(0, 0, '0, 0, 0);

    // Clean frame, consumer always ready.
    for (int s = 0; s < N_SIZE; s++) run_cycle(1, s, 1, 0);
    idle(4, 1);

    // Fill to FIFO_DEPTH with consumer stalled, then overflow one row.
    for (int i = 0; i < FIFO_DEPTH; i++) run_cycle(1, i % N_SIZE, 0, 0);
    run_cycle(1, 3, 0, 0);
    idle(2, 0);
    // Full FIFO, push with simultaneous pop is accepted.
    run_cycle(1, 4, 1, 0);
    run_cycle(0, 0, 1, 1);
    idle(10, 1);

    // Out-of-order rows: dropped in IDLE, kept and resynced inside a frame.
    run_cycle(1, 2, 1, 0);
    run_cycle(1, 0, 1, 0);
    run_cycle(1, 1, 1, 0);
    run_cycle(1, 3, 1, 0);
    run_cycle(1, 4, 1, 0);
    idle(3, 1);
    run_cycle(0, 0, 1, 1);
    idle(2, 1);

    // Back-to-back frames with ready toggling every cycle.
    for (int i = 0; i < 2*N_SIZE; i++) run_cycle(1, i % N_SIZE, i % 2 == 0, 0);
    for (int i = 0; i < 14; i++) run_cycle(0, 0, i % 2 == 0, 0);

    // Reset in the middle of a frame with rows buffered.
    for (int s = 0; s < 3; s++) run_cycle(1, s, 0, 0);
    do_reset();
    for (int s = 0; s < N_SIZE; s++) run_cycle(1, s, 1, 0);
    idle(8, 1);

    // Random traffic: mostly in-order rows, occasional wrong index and clears.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = ($urandom_range(0, 9) == 0) ? $urandom_range(0, N_SIZE-1) : md_next;
      run_cycle($urandom_range(0, 3) != 0, sel, $urandom_range(0, 2) != 0,
                $urandom_range(0, 30) == 0);
    end
    idle(FIFO_DEPTH + 4, 1);
    @(negedge clk);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Sits directly downstream of the systolic-array controller and the output row mux.
- Captures one result row per cycle while the controller asserts its output-valid, tagged by the controller's row select.
- Buffers rows in a small FIFO and streams them to the system side over a valid/ready handshake, with row index, last-row flag and sequence/overflow error reporting.

Parameters:
- DATAWIDTH, 16, operand width (matches array)
- N_SIZE, 5, array dimension; rows per matrix and elements per row
- ACC_WIDTH, 2*DATAWIDTH, width of one result element
- FIFO_DEPTH, 8, rows of buffering; any integer >= 2, not required to be a power of 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- row_valid_in  in  1  row present this cycle (controller valid_out)
- row_sel_in  in  $clog2(N_SIZE)  row index of row_data_in (controller sel)
- row_data_in  in  N_SIZE*ACC_WIDTH  selected row; element k at bits [k*ACC_WIDTH +: ACC_WIDTH]
- m_valid  out  1  output row available
- m_ready  in  1  consumer accepts row
- m_data  out  N_SIZE*ACC_WIDTH  head row data
- m_row  out  $clog2(N_SIZE)  head row index
- m_last  out  1  head row is row N_SIZE-1
- mat_done  out  1  one-cycle pulse: last row of a matrix popped
- busy  out  1  FIFO non-empty or frame in progress
- seq_err  out  1  sticky: out-of-order row seen
- ovf_err  out  1  sticky: row dropped, FIFO full
- clear_err  in  1  synchronous clear of seq_err/ovf_err

Behaviour:
- Reset (async, rst_n low):
  - FIFO empty; state IDLE; exp_row=0.
  - Outputs: m_valid=0, m_data=0, m_row=0, m_last=0, mat_done=0, busy=0, seq_err=0, ovf_err=0.
  - Reset mid-frame discards all buffered rows; no pulses are generated.
- Framing FSM, states IDLE and COLLECT:
  - IDLE: row_valid_in with row_sel_in==0 -> push row, exp_row=1, go to COLLECT (when N_SIZE==1, stay in IDLE).
  - IDLE: row_valid_in with row_sel_in!=0 -> drop row, set seq_err, stay in IDLE.
  - COLLECT: row_valid_in with row_sel_in==exp_row -> push row, exp_row+1.
  - COLLECT: when row_sel_in==N_SIZE-1 is pushed, exp_row wraps to 0 and the FSM returns to IDLE.
  - COLLECT: row_valid_in with row_sel_in!=exp_row -> push anyway (tagged with its own row_sel_in), set seq_err, resync exp_row=row_sel_in+1 (wrapping and going to IDLE if row_sel_in==N_SIZE-1).
  - COLLECT with row_valid_in low: hold; gaps inside a frame are legal.
- FIFO entry = {row_sel_in, last=(row_sel_in==N_SIZE-1), row_data_in}.
  - Pointers wrap from FIFO_DEPTH-1 to 0; occupancy count is 0..FIFO_DEPTH.
- Push when full:
  - Without a pop in the same cycle: row dropped, ovf_err set; the FSM/exp_row still advance as if the row had been accepted.
  - With a pop in the same cycle (m_valid & m_ready): push accepted, occupancy unchanged.
- Output is first-word fall-through from registered storage:
  - m_valid = non-empty.
  - m_data/m_row/m_last show the head entry.
  - Latency: row sampled at edge t -> m_valid high in cycle after t (no same-cycle bypass when empty).
  - Pop on the clock edge where m_valid & m_ready. m_data is stable while m_valid & !m_ready.
  - When empty, m_data/m_row/m_last hold their last value (0 after reset).
- mat_done: registered, high the cycle after a pop whose entry has last=1.
- busy = non-empty OR state==COLLECT.
- Sticky flags:
  - seq_err/ovf_err stay set until clear_err.
  - clear_err and a new error in the same cycle -> flag remains set (set wins).

Optional Feature:
- Macro: RESULT_DRAIN_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments by 1 per error event (dropped-on-full row, or seq mismatch). A simultaneous overflow and mismatch on the same row counts 1.
  - Saturates at 255.
  - clear_err resets it to 0; clear_err with a simultaneous event -> 1.
- When undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- N_SIZE=5, m_ready=1, rows sel 0,1,2,3,4 on 5 consecutive cycles -> m_valid high 5 cycles starting 1 cycle later, m_row 0..4, m_last only on row 4, mat_done pulse 1 cycle after row 4 popped, no errors.
- m_ready=0, push 8 rows (sel 0..4 then 0..2) into FIFO_DEPTH=8, then a 9th row (sel 3) -> ovf_err=1, FIFO holds first 8 rows in order; row 3 lost; with the macro defined, err_cnt=1.
- FIFO full, row pushed while m_ready=1 -> push accepted, occupancy stays 8, ovf_err stays 0, output order preserved.
- IDLE, row sel 2 -> dropped, seq_err=1, m_valid stays 0; then sel 0,1,3,4 -> all pushed; seq_err remains set; exp_row resyncs after 3; clear_err -> seq_err=0.
- m_ready toggled 1/0 every cycle with back-to-back frames -> no loss, m_data stable while stalled, two mat_done pulses.
- rst_n asserted with 3 rows buffered in COLLECT -> all outputs 0 immediately; after release, a fresh frame sel 0..4 drains correctly.
